// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module  : serial_subtractor_if
// Brief   : Start/done handshake, operands and results of the serial subtractor.
// Revision: 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             sbit;
  logic             sbit_valid;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, sbit, sbit_valid
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, sbit, sbit_valid
  );
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module  : serial_subtractor
// Brief   : Bit-serial A - B, LSB first, one full-subtractor cell plus borrow FF.
// Revision: 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q,      state_d;
  logic [WIDTH-1:0] a_sr_q,       a_sr_d;
  logic [WIDTH-1:0] b_sr_q,       b_sr_d;
  logic [WIDTH-1:0] res_sr_q,     res_sr_d;
  logic             br_q,         br_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic             busy_q,       busy_d;
  logic             done_q,       done_d;
  logic [WIDTH-1:0] diff_q,       diff_d;
  logic             borrow_q,     borrow_d;
  logic             sbit_q,       sbit_d;
  logic             sbit_valid_q, sbit_valid_d;

  logic             w_dbit;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_next;

  assign w_dbit     = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
  assign w_bout     = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
  assign w_res_next = {w_dbit, res_sr_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_sr_q       <= '0;
      b_sr_q       <= '0;
      res_sr_q     <= '0;
      br_q         <= 1'b0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      diff_q       <= '0;
      borrow_q     <= 1'b0;
      sbit_q       <= 1'b0;
      sbit_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_sr_q       <= a_sr_d;
      b_sr_q       <= b_sr_d;
      res_sr_q     <= res_sr_d;
      br_q         <= br_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      diff_q       <= diff_d;
      borrow_q     <= borrow_d;
      sbit_q       <= sbit_d;
      sbit_valid_q <= sbit_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    res_sr_d     = res_sr_q;
    br_d         = br_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    diff_d       = diff_q;
    borrow_d     = borrow_q;
    sbit_d       = sbit_q;
    sbit_valid_d = 1'b0;

    case (state_q)
      // DONE accepts a new start exactly like IDLE, giving back-to-back operation.
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          br_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        a_sr_d       = a_sr_q >> 1;
        b_sr_d       = b_sr_q >> 1;
        res_sr_d     = w_res_next;
        br_d         = w_bout;
        cnt_d        = cnt_q + CNT_W'(1);
        sbit_d       = w_dbit;
        sbit_valid_d = 1'b1;
        if (cnt_q == C_LAST) begin
          diff_d   = w_res_next;
          borrow_d = w_bout;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow     = borrow_q;
  assign bus.sbit       = sbit_q;
  assign bus.sbit_valid = sbit_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_subtractor
// Brief   : Randomised self-checking bench for serial_subtractor (WIDTH=8).
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int W   = 8;
  localparam int MOD = 1 << W;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic [W-1:0] prev_diff;

  serial_subtractor_if #(.WIDTH(W)) u_bus ();

  serial_subtractor #(.WIDTH(W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ref_diff(input int ai, input int bi);
    return (ai - bi + MOD) % MOD;
  endfunction

  function automatic int ref_borrow(input int ai, input int bi);
    return (ai < bi) ? 1 : 0;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(u_bus.busy),       0);
    check({tag, "_done"},  32'(u_bus.done),       0);
    check({tag, "_diff"},  32'(u_bus.diff),       0);
    check({tag, "_borr"},  32'(u_bus.borrow),     0);
    check({tag, "_sbit"},  32'(u_bus.sbit),       0);
    check({tag, "_sval"},  32'(u_bus.sbit_valid), 0);
  endtask

  // One full operation, checked cycle by cycle: stream, latency, hold of old result.
  task automatic run_op(input int ai, input int bi);
    int ed, eb;
    ed = ref_diff(ai, bi);
    eb = ref_borrow(ai, bi);
    @(negedge clk);
    check("idle_sval", 32'(u_bus.sbit_valid), 0);
    check("idle_sbit", 32'(u_bus.sbit),       32'(prev_diff[W-1]));
    check("idle_busy", 32'(u_bus.busy),       0);
    u_bus.start = 1'b1;
    u_bus.a     = W'(ai);
    u_bus.b     = W'(bi);
    @(negedge clk);
    u_bus.start = 1'b0;
    u_bus.a     = W'($urandom);
    u_bus.b     = W'($urandom);
    check("busy_rise", 32'(u_bus.busy), 1);
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      check("sval", 32'(u_bus.sbit_valid), 1);
      check("sbit", 32'(u_bus.sbit),       32'((ed >> (i - 1)) & 1));
      if (i < W) begin
        check("done_early", 32'(u_bus.done), 0);
        check("busy_mid",   32'(u_bus.busy), 1);
        check("diff_hold",  32'(u_bus.diff), 32'(prev_diff));
      end else begin
        check("done",   32'(u_bus.done),   1);
        check("busy_0", 32'(u_bus.busy),   0);
        check("diff",   32'(u_bus.diff),   32'(ed));
        check("borrow", 32'(u_bus.borrow), 32'(eb));
      end
    end
    prev_diff = W'(ed);
  endtask

  int vec_a [8] = '{8'h5A, 8'h10, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h80};
  int vec_b [8] = '{8'h3C, 8'h20, 8'h01, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h7F};

  initial begin
    int ndone;
    n_tests     = 0;
    n_fail      = 0;
    prev_diff   = '0;
    rst_n       = 1'b0;
    u_bus.start = 1'b0;
    u_bus.a     = '0;
    u_bus.b     = '0;

    repeat (3) @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) run_op(vec_a[v], vec_b[v]);

    // Start held high; operands zeroed after acceptance.
    @(negedge clk);
    u_bus.start = 1'b1;
    u_bus.a     = 8'hFF;
    u_bus.b     = 8'h01;
    @(negedge clk);
    u_bus.a = 8'h00;
    u_bus.b = 8'h00;
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      check("hold_done1", 32'(u_bus.done), (i == W) ? 1 : 0);
      if (i == W) begin
        check("hold_diff1", 32'(u_bus.diff),   8'hFE);
        check("hold_borr1", 32'(u_bus.borrow), 0);
      end
    end
    for (int j = 1; j <= W + 1; j++) begin
      @(negedge clk);
      if (j == 1) check("b2b_busy", 32'(u_bus.busy), 1);
      check("hold_done2", 32'(u_bus.done), (j == W + 1) ? 1 : 0);
      if (j == W + 1) begin
        check("hold_diff2", 32'(u_bus.diff),   8'h00);
        check("hold_borr2", 32'(u_bus.borrow), 0);
      end
    end
    u_bus.start = 1'b0;
    prev_diff   = 8'h00;

    // Extra start pulses while busy must be ignored.
    @(negedge clk);
    @(negedge clk);
    u_bus.start = 1'b1;
    u_bus.a     = 8'h33;
    u_bus.b     = 8'h11;
    @(negedge clk);
    u_bus.start = 1'b0;
    ndone = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (u_bus.done) ndone++;
      if (i == W) begin
        check("xtra_diff", 32'(u_bus.diff),   8'h22);
        check("xtra_borr", 32'(u_bus.borrow), 0);
      end
      u_bus.start = (i <= 7 && (i % 2) == 1) ? 1'b1 : 1'b0;
      u_bus.a     = W'($urandom);
      u_bus.b     = W'($urandom);
    end
    u_bus.start = 1'b0;
    check("xtra_ndone", 32'(ndone), 1);
    prev_diff = 8'h22;

    // Asynchronous reset in the middle of the 4th shift cycle.
    @(negedge clk);
    u_bus.start = 1'b1;
    u_bus.a     = 8'h55;
    u_bus.b     = 8'h0F;
    @(negedge clk);
    u_bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("arst");
    @(negedge clk);
    rst_n     = 1'b1;
    prev_diff = '0;
    ndone     = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (u_bus.done) ndone++;
    end
    check("arst_ndone", 32'(ndone), 0);
    check("arst_diff",  32'(u_bus.diff), 0);
    run_op(8'h07, 8'h03);

    for (int n = 0; n < 3000; n++) run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
